// File: rtl/hd_timing_pkg.sv
// 720p50 timing constants and helpers shared by the HD timing generator and
// the upsampler's vertical translator.
package hd_timing_pkg;

    localparam int unsigned H_ACT_720P  = 1280;
    localparam int unsigned H_FP_720P   = 440;
    localparam int unsigned H_SYNC_720P = 40;
    localparam int unsigned H_BP_720P   = 220;
    localparam int unsigned V_ACT_720P  = 720;
    localparam int unsigned V_FP_720P   = 5;
    localparam int unsigned V_SYNC_720P = 5;
    localparam int unsigned V_BP_720P   = 20;

    localparam int unsigned CLK_DIV_DEFAULT   = 2;
    localparam int unsigned LOCK_LINE_DEFAULT = 0;

    localparam int unsigned HCOUNT_W = 12;
    localparam int unsigned VCOUNT_W = 11;

    // Total span of a line or frame: active + front porch + sync + back porch.
    function automatic int unsigned span_total(input int unsigned act,
                                               input int unsigned fp,
                                               input int unsigned sync,
                                               input int unsigned bp);
        return act + fp + sync + bp;
    endfunction

    localparam int unsigned H_TOTAL_720P =
        span_total(H_ACT_720P, H_FP_720P, H_SYNC_720P, H_BP_720P);
    localparam int unsigned V_TOTAL_720P =
        span_total(V_ACT_720P, V_FP_720P, V_SYNC_720P, V_BP_720P);

    // Per-pixel video qualifiers, registered together so they never skew.
    typedef struct packed {
        logic frame_start;
        logic de;
        logic vsync;
        logic hsync;
    } hd_flags_t;

endpackage

// File: rtl/hd_timing_gen_if.sv
// Genlock inputs and video timing outputs of the HD timing generator.
interface hd_timing_gen_if;
    import hd_timing_pkg::*;

    logic                i_lock_en;
    logic                i_frame_sync;
    logic                o_hd_clk;
    logic                o_pix_en;
    logic                o_hsync;
    logic                o_vsync;
    logic                o_de;
    logic [HCOUNT_W-1:0] o_hcount;
    logic [VCOUNT_W-1:0] o_vcount;
    logic                o_frame_start;
    logic                o_lock_jump;

    modport master (
        input  i_lock_en, i_frame_sync,
        output o_hd_clk, o_pix_en, o_hsync, o_vsync, o_de,
               o_hcount, o_vcount, o_frame_start, o_lock_jump
    );

    modport slave (
        output i_lock_en, i_frame_sync,
        input  o_hd_clk, o_pix_en, o_hsync, o_vsync, o_de,
               o_hcount, o_vcount, o_frame_start, o_lock_jump
    );

endinterface

// File: rtl/hd_pix_clk_div.sv
// Free-running pixel divider: one-clk pixel strobe every CLK_DIV clks and a
// square pixel clock whose falling edge sits at mid-pixel.
module hd_pix_clk_div #(
    parameter int unsigned CLK_DIV = 2
) (
    input  logic clk,
    input  logic reset,
    output logic o_tick_c,
    output logic o_pix_en,
    output logic o_hd_clk
);

    localparam int unsigned DIV_W = $clog2(CLK_DIV);

    logic [DIV_W-1:0] div_q, div_d;
    logic             pix_en_q, pix_en_d;
    logic             hd_clk_q, hd_clk_d;

    // The tick is the clk in which the registered strobe and counters update.
    always_comb begin
        o_tick_c = (div_q == DIV_W'(CLK_DIV - 1));
        div_d    = o_tick_c ? '0 : div_q + DIV_W'(1);
        pix_en_d = o_tick_c;
        hd_clk_d = (div_d < DIV_W'(CLK_DIV / 2));
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            div_q    <= '0;
            pix_en_q <= 1'b0;
            hd_clk_q <= 1'b1;
        end else begin
            div_q    <= div_d;
            pix_en_q <= pix_en_d;
            hd_clk_q <= hd_clk_d;
        end
    end

    assign o_pix_en = pix_en_q;
    assign o_hd_clk = hd_clk_q;

endmodule

// File: rtl/hd_timing_gen.sv
// HD raster timing generator with line-granular genlock to an upstream frame
// pulse; every output is registered on the pixel-strobe clk edge.
module hd_timing_gen
    import hd_timing_pkg::*;
#(
    parameter int unsigned H_ACT     = H_ACT_720P,
    parameter int unsigned H_FP      = H_FP_720P,
    parameter int unsigned H_SYNC    = H_SYNC_720P,
    parameter int unsigned H_BP      = H_BP_720P,
    parameter int unsigned V_ACT     = V_ACT_720P,
    parameter int unsigned V_FP      = V_FP_720P,
    parameter int unsigned V_SYNC    = V_SYNC_720P,
    parameter int unsigned V_BP      = V_BP_720P,
    parameter int unsigned CLK_DIV   = CLK_DIV_DEFAULT,
    parameter int unsigned LOCK_LINE = LOCK_LINE_DEFAULT
) (
    input  logic            clk,
    input  logic            reset,
    hd_timing_gen_if.master bus
);

    localparam int unsigned H_TOTAL  = span_total(H_ACT, H_FP, H_SYNC, H_BP);
    localparam int unsigned V_TOTAL  = span_total(V_ACT, V_FP, V_SYNC, V_BP);
    localparam int unsigned HS_START = H_ACT + H_FP;
    localparam int unsigned HS_END   = H_ACT + H_FP + H_SYNC;
    localparam int unsigned VS_START = V_ACT + V_FP;
    localparam int unsigned VS_END   = V_ACT + V_FP + V_SYNC;

    localparam logic [VCOUNT_W-1:0] LOCK_V = VCOUNT_W'(LOCK_LINE);

    logic                tick_c;
    logic                h_last_c;
    logic                lock_hit_c;
    logic [VCOUNT_W-1:0] v_inc_c;

    logic [HCOUNT_W-1:0] h_q, h_d;
    logic [VCOUNT_W-1:0] v_q, v_d;
    logic                primed_q, primed_d;
    logic                pend_q, pend_d;
    logic                lock_jump_q, lock_jump_d;
    hd_flags_t           flags_q, flags_d;

    hd_pix_clk_div #(
        .CLK_DIV (CLK_DIV)
    ) u_pix_clk_div (
        .clk      (clk),
        .reset    (reset),
        .o_tick_c (tick_c),
        .o_pix_en (bus.o_pix_en),
        .o_hd_clk (bus.o_hd_clk)
    );

    // The first tick after reset presents pixel (0,0) instead of advancing,
    // so the raster restarts cleanly with a frame_start.
    always_comb begin
        h_last_c   = (h_q == HCOUNT_W'(H_TOTAL - 1));
        v_inc_c    = (v_q == VCOUNT_W'(V_TOTAL - 1)) ? '0 : v_q + VCOUNT_W'(1);
        lock_hit_c = bus.i_lock_en && (pend_q || bus.i_frame_sync);

        h_d                 = h_q;
        v_d                 = v_q;
        primed_d            = primed_q;
        pend_d              = pend_q;
        lock_jump_d         = 1'b0;
        flags_d             = flags_q;
        flags_d.frame_start = 1'b0;

        if (!bus.i_lock_en) begin
            pend_d = 1'b0;
        end else if (bus.i_frame_sync) begin
            pend_d = 1'b1;
        end

        if (tick_c) begin
            primed_d = 1'b1;
            if (primed_q) begin
                if (h_last_c) begin
                    h_d = '0;
                    // Genlock only ever rewrites the line number, at a line wrap.
                    if (lock_hit_c) begin
                        v_d         = LOCK_V;
                        lock_jump_d = (LOCK_V != v_inc_c);
                        pend_d      = 1'b0;
                    end else begin
                        v_d = v_inc_c;
                    end
                end else begin
                    h_d = h_q + HCOUNT_W'(1);
                end
            end
            flags_d.hsync       = (h_d >= HCOUNT_W'(HS_START)) && (h_d < HCOUNT_W'(HS_END));
            flags_d.vsync       = (v_d >= VCOUNT_W'(VS_START)) && (v_d < VCOUNT_W'(VS_END));
            flags_d.de          = (h_d < HCOUNT_W'(H_ACT)) && (v_d < VCOUNT_W'(V_ACT));
            flags_d.frame_start = (h_d == '0) && (v_d == '0);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            h_q         <= '0;
            v_q         <= '0;
            primed_q    <= 1'b0;
            pend_q      <= 1'b0;
            lock_jump_q <= 1'b0;
            flags_q     <= '0;
        end else begin
            h_q         <= h_d;
            v_q         <= v_d;
            primed_q    <= primed_d;
            pend_q      <= pend_d;
            lock_jump_q <= lock_jump_d;
            flags_q     <= flags_d;
        end
    end

    assign bus.o_hcount      = h_q;
    assign bus.o_vcount      = v_q;
    assign bus.o_hsync       = flags_q.hsync;
    assign bus.o_vsync       = flags_q.vsync;
    assign bus.o_de          = flags_q.de;
    assign bus.o_frame_start = flags_q.frame_start;
    assign bus.o_lock_jump   = lock_jump_q;

endmodule

// File: tb/tb_hd_timing_gen.sv
// Scoreboard bench for hd_timing_gen on a reduced raster so whole frames fit
// in a short run.
module tb_hd_timing_gen;
    import hd_timing_pkg::*;

    localparam int unsigned TH_ACT = 16, TH_FP = 4, TH_SYNC = 3, TH_BP = 5;
    localparam int unsigned TV_ACT = 10, TV_FP = 2, TV_SYNC = 2, TV_BP = 3;
    localparam int unsigned TH_TOTAL  = TH_ACT + TH_FP + TH_SYNC + TH_BP;  // 28
    localparam int unsigned TV_TOTAL  = TV_ACT + TV_FP + TV_SYNC + TV_BP;  // 17
    localparam int unsigned FRAME_PIX = TH_TOTAL * TV_TOTAL;
    localparam int unsigned NONE      = 9999;

    typedef struct packed {
        logic [11:0] h;
        logic [10:0] v;
        logic        hs;
        logic        vs;
        logic        de;
        logic        fs;
        logic        lj;
    } pix_t;

    logic clk = 1'b0;
    logic reset;
    int unsigned n_cmp = 0;
    int unsigned n_bad = 0;
    pix_t exp_q[$];

    hd_timing_gen_if bus ();

    hd_timing_gen #(
        .H_ACT(TH_ACT), .H_FP(TH_FP), .H_SYNC(TH_SYNC), .H_BP(TH_BP),
        .V_ACT(TV_ACT), .V_FP(TV_FP), .V_SYNC(TV_SYNC), .V_BP(TV_BP),
        .CLK_DIV(2), .LOCK_LINE(0)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, got no finish, required finish");
        $fatal(1, "watchdog");
    end

    // Expected video qualifiers for a raster position, straight from the timing definition.
    function automatic pix_t model(input int unsigned h, input int unsigned v, input logic lj);
        pix_t p;
        p.h  = 12'(h);
        p.v  = 11'(v);
        p.hs = (h >= TH_ACT + TH_FP) && (h < TH_ACT + TH_FP + TH_SYNC);
        p.vs = (v >= TV_ACT + TV_FP) && (v < TV_ACT + TV_FP + TV_SYNC);
        p.de = (h < TH_ACT) && (v < TV_ACT);
        p.fs = (h == 0) && (v == 0);
        p.lj = lj;
        return p;
    endfunction

    function automatic void adv(inout int unsigned h, inout int unsigned v);
        if (h == TH_TOTAL - 1) begin
            h = 0;
            v = (v == TV_TOTAL - 1) ? 0 : v + 1;
        end else begin
            h = h + 1;
        end
    endfunction

    function automatic string fmt(input pix_t p);
        return $sformatf("h=%0d v=%0d hs=%b vs=%b de=%b fs=%b lj=%b",
                         p.h, p.v, p.hs, p.vs, p.de, p.fs, p.lj);
    endfunction

    function automatic pix_t sample();
        pix_t p;
        p.h  = bus.o_hcount;
        p.v  = bus.o_vcount;
        p.hs = bus.o_hsync;
        p.vs = bus.o_vsync;
        p.de = bus.o_de;
        p.fs = bus.o_frame_start;
        p.lj = bus.o_lock_jump;
        return p;
    endfunction

    task automatic push_line_rest(input int unsigned h_from, input int unsigned v);
        for (int unsigned h = h_from; h < TH_TOTAL; h++) exp_q.push_back(model(h, v, 1'b0));
    endtask

    // Wait (bounded) for the next pixel strobe; sample 1 time unit after the edge.
    task automatic wait_pix(output pix_t got, output int unsigned cyc, output bit ok);
        ok  = 1'b0;
        cyc = 0;
        got = '0;
        for (int i = 0; i < 16; i++) begin
            @(posedge clk);
            #1;
            cyc++;
            if (bus.o_pix_en === 1'b1) begin
                got = sample();
                ok  = 1'b1;
                break;
            end
        end
        if (!ok) begin
            n_cmp++;
            n_bad++;
            $display("FAIL pix_timeout: o_pix_en seen=0, required=1 within 16 clks");
        end
    endtask

    task automatic seek(input int unsigned h, input int unsigned v);
        pix_t got;
        int unsigned cyc;
        bit ok;
        bit found = 1'b0;
        for (int i = 0; i < int'(2 * FRAME_PIX + 4); i++) begin
            wait_pix(got, cyc, ok);
            if (!ok) break;
            if (got.h == 12'(h) && got.v == 11'(v)) begin
                found = 1'b1;
                break;
            end
        end
        if (!found) begin
            n_cmp++;
            n_bad++;
            $display("FAIL seek: position h=%0d v=%0d not reached, required reached", h, v);
        end
    endtask

    // One-clk frame pulse sampled by the clk edge that follows a pixel sample.
    task automatic pulse_mid();
        bus.i_frame_sync = 1'b1;
        @(posedge clk);
        #1;
        bus.i_frame_sync = 1'b0;
    endtask

    task automatic test_reset();
        pix_t got, exp;
        int unsigned cyc;
        bit ok;
        reset = 1'b1;
        bus.i_lock_en = 1'b0;
        bus.i_frame_sync = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        n_cmp++;
        if (bus.o_hd_clk !== 1'b1) begin
            n_bad++;
            $display("FAIL reset_hd_clk: got %b, required 1", bus.o_hd_clk);
        end
        n_cmp++;
        if ({bus.o_pix_en, bus.o_hsync, bus.o_vsync, bus.o_de, bus.o_frame_start, bus.o_lock_jump} !== 6'b0) begin
            n_bad++;
            $display("FAIL reset_flags: got %b%b%b%b%b%b, required 000000", bus.o_pix_en, bus.o_hsync,
                     bus.o_vsync, bus.o_de, bus.o_frame_start, bus.o_lock_jump);
        end
        n_cmp++;
        if ({bus.o_hcount, bus.o_vcount} !== 23'd0) begin
            n_bad++;
            $display("FAIL reset_counts: got h=%0d v=%0d, required h=0 v=0", bus.o_hcount, bus.o_vcount);
        end
        reset = 1'b0;
        exp_q.push_back(model(0, 0, 1'b0));
        wait_pix(got, cyc, ok);
        if (ok) begin
            n_cmp++;
            if (cyc != 2) begin
                n_bad++;
                $display("FAIL reset_first_pix_latency: got %0d clks, required 2", cyc);
            end
            exp = exp_q.pop_front();
            n_cmp++;
            if (got !== exp) begin
                n_bad++;
                $display("FAIL reset_first_pix: got %s, required %s", fmt(got), fmt(exp));
            end
        end
        exp_q.delete();
    endtask

    task automatic test_free_run();
        pix_t got, exp;
        int unsigned cyc;
        bit ok;
        int unsigned h = 0, v = 0;
        int unsigned de_n = 0, fs_n = 0, hs_n = 0, vs_n = 0, per_bad = 0, hd_bad = 0;
        int unsigned hs_first = NONE, vs_first = NONE;
        for (int i = 0; i < int'(FRAME_PIX); i++) begin
            adv(h, v);
            exp_q.push_back(model(h, v, 1'b0));
            wait_pix(got, cyc, ok);
            if (!ok) break;
            if (cyc != 2) per_bad++;
            if (bus.o_hd_clk !== 1'b1) hd_bad++;
            if (got.de) de_n++;
            if (got.fs) fs_n++;
            if (got.hs) hs_n++;
            if (got.vs) vs_n++;
            if (got.hs && hs_first == NONE) hs_first = 32'(got.h);
            if (got.vs && vs_first == NONE) vs_first = 32'(got.v);
            exp = exp_q.pop_front();
            n_cmp++;
            if (got !== exp) begin
                n_bad++;
                $display("FAIL free_run_pixel: got %s, required %s", fmt(got), fmt(exp));
            end
        end
        exp_q.delete();
        n_cmp++;
        if (per_bad != 0) begin n_bad++; $display("FAIL pix_en_period: got %0d periods not 2 clks, required 0", per_bad); end
        n_cmp++;
        if (hd_bad != 0) begin n_bad++; $display("FAIL hd_clk_high_at_pix: got %0d low samples, required 0", hd_bad); end
        n_cmp++;
        if (de_n != TH_ACT * TV_ACT) begin n_bad++; $display("FAIL de_per_frame: got %0d, required %0d", de_n, TH_ACT * TV_ACT); end
        n_cmp++;
        if (fs_n != 1) begin n_bad++; $display("FAIL frame_start_per_frame: got %0d, required 1", fs_n); end
        n_cmp++;
        if (hs_n != TH_SYNC * TV_TOTAL) begin n_bad++; $display("FAIL hsync_pixels: got %0d, required %0d", hs_n, TH_SYNC * TV_TOTAL); end
        n_cmp++;
        if (vs_n != TV_SYNC * TH_TOTAL) begin n_bad++; $display("FAIL vsync_pixels: got %0d, required %0d", vs_n, TV_SYNC * TH_TOTAL); end
        n_cmp++;
        if (hs_first != TH_ACT + TH_FP) begin n_bad++; $display("FAIL hsync_start: got %0d, required %0d", hs_first, TH_ACT + TH_FP); end
        n_cmp++;
        if (vs_first != TV_ACT + TV_FP) begin n_bad++; $display("FAIL vsync_start: got %0d, required %0d", vs_first, TV_ACT + TV_FP); end
        @(posedge clk);
        #1;
        n_cmp++;
        if (bus.o_hd_clk !== 1'b0 || bus.o_pix_en !== 1'b0) begin
            n_bad++;
            $display("FAIL hd_clk_mid_pixel: got hd_clk=%b pix_en=%b, required 0 0", bus.o_hd_clk, bus.o_pix_en);
        end
    endtask

    task automatic test_genlock_jump();
        pix_t got, exp;
        int unsigned cyc;
        bit ok;
        bus.i_lock_en = 1'b1;
        seek(3, 5);
        pulse_mid();
        push_line_rest(4, 5);
        exp_q.push_back(model(0, 0, 1'b1));
        exp_q.push_back(model(1, 0, 1'b0));
        while (exp_q.size() > 0) begin
            wait_pix(got, cyc, ok);
            if (!ok) break;
            exp = exp_q.pop_front();
            n_cmp++;
            if (got !== exp) begin
                n_bad++;
                $display("FAIL genlock_jump: got %s, required %s", fmt(got), fmt(exp));
            end
        end
        exp_q.delete();
    endtask

    task automatic test_genlock_last_line();
        pix_t got, exp;
        int unsigned cyc;
        bit ok;
        seek(3, TV_TOTAL - 1);
        pulse_mid();
        push_line_rest(4, TV_TOTAL - 1);
        push_line_rest(0, 0);
        exp_q.push_back(model(0, 1, 1'b0));
        while (exp_q.size() > 0) begin
            wait_pix(got, cyc, ok);
            if (!ok) break;
            exp = exp_q.pop_front();
            n_cmp++;
            if (got !== exp) begin
                n_bad++;
                $display("FAIL genlock_last_line: got %s, required %s", fmt(got), fmt(exp));
            end
        end
        exp_q.delete();
    endtask

    task automatic test_simultaneous();
        pix_t got, exp;
        int unsigned cyc;
        bit ok;
        seek(TH_TOTAL - 1, 7);
        @(posedge clk);
        #1;
        bus.i_frame_sync = 1'b1;
        exp_q.push_back(model(0, 0, 1'b1));
        wait_pix(got, cyc, ok);
        bus.i_frame_sync = 1'b0;
        if (ok) begin
            exp = exp_q.pop_front();
            n_cmp++;
            if (got !== exp) begin
                n_bad++;
                $display("FAIL same_clk_wrap: got %s, required %s", fmt(got), fmt(exp));
            end
        end
        exp_q.delete();
        seek(3, 3);
        pulse_mid();
        seek(6, 3);
        pulse_mid();
        push_line_rest(7, 3);
        exp_q.push_back(model(0, 0, 1'b1));
        push_line_rest(1, 0);
        exp_q.push_back(model(0, 1, 1'b0));
        while (exp_q.size() > 0) begin
            wait_pix(got, cyc, ok);
            if (!ok) break;
            exp = exp_q.pop_front();
            n_cmp++;
            if (got !== exp) begin
                n_bad++;
                $display("FAIL pulse_while_pending: got %s, required %s", fmt(got), fmt(exp));
            end
        end
        exp_q.delete();
    endtask

    task automatic test_lock_disabled();
        pix_t got, exp;
        int unsigned cyc;
        bit ok;
        bus.i_lock_en = 1'b0;
        seek(3, 4);
        pulse_mid();
        push_line_rest(4, 4);
        exp_q.push_back(model(0, 5, 1'b0));
        while (exp_q.size() > 0) begin
            wait_pix(got, cyc, ok);
            if (!ok) break;
            exp = exp_q.pop_front();
            n_cmp++;
            if (got !== exp) begin
                n_bad++;
                $display("FAIL lock_disabled: got %s, required %s", fmt(got), fmt(exp));
            end
        end
        exp_q.delete();
        bus.i_lock_en = 1'b1;
        seek(3, 8);
        pulse_mid();
        seek(5, 8);
        bus.i_lock_en = 1'b0;
        push_line_rest(6, 8);
        exp_q.push_back(model(0, 9, 1'b0));
        while (exp_q.size() > 0) begin
            wait_pix(got, cyc, ok);
            if (!ok) break;
            exp = exp_q.pop_front();
            n_cmp++;
            if (got !== exp) begin
                n_bad++;
                $display("FAIL lock_en_drop_clears: got %s, required %s", fmt(got), fmt(exp));
            end
        end
        exp_q.delete();
    endtask

    task automatic test_mid_reset();
        pix_t got, exp;
        int unsigned cyc;
        bit ok;
        seek(5, 6);
        reset = 1'b1;
        @(posedge clk);
        #1;
        n_cmp++;
        if ({bus.o_hd_clk, bus.o_pix_en, bus.o_hsync, bus.o_vsync, bus.o_de, bus.o_frame_start,
             bus.o_lock_jump, bus.o_hcount, bus.o_vcount} !== {1'b1, 6'b0, 23'd0}) begin
            n_bad++;
            $display("FAIL mid_reset_state: got hd_clk=%b pix_en=%b %s, required hd_clk=1 pix_en=0 all zero",
                     bus.o_hd_clk, bus.o_pix_en, fmt(sample()));
        end
        @(posedge clk);
        #1;
        reset = 1'b0;
        exp_q.push_back(model(0, 0, 1'b0));
        wait_pix(got, cyc, ok);
        if (ok) begin
            n_cmp++;
            if (cyc != 2) begin
                n_bad++;
                $display("FAIL mid_reset_latency: got %0d clks, required 2", cyc);
            end
            exp = exp_q.pop_front();
            n_cmp++;
            if (got !== exp) begin
                n_bad++;
                $display("FAIL mid_reset_first_pix: got %s, required %s", fmt(got), fmt(exp));
            end
        end
        exp_q.delete();
    endtask

    initial begin
        reset = 1'b1;
        bus.i_lock_en = 1'b0;
        bus.i_frame_sync = 1'b0;
        test_reset();
        test_free_run();
        test_genlock_jump();
        test_genlock_last_line();
        test_simultaneous();
        test_lock_disabled();
        test_mid_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/hd_timing_gen.md
HD_TIMING_GEN -- requirements
Module: hd_timing_gen

Interface
REQ-001 SHALL have parameters, one per line: name, default, meaning.
- H_ACT, 1280, active pixels per line
- H_FP, 440, horizontal front porch, pixels
- H_SYNC, 40, hsync width, pixels
- H_BP, 220, horizontal back porch, pixels
- V_ACT, 720, active lines
- V_FP, 5, vertical front porch, lines
- V_SYNC, 5, vsync width, lines
- V_BP, 20, vertical back porch, lines
- CLK_DIV, 2, clk cycles per pixel (even, >=2)
- LOCK_LINE, 0, vcount loaded on a genlock event
REQ-002 SHALL have ports, one per line: name, direction, width, meaning.
- clk, in, 1, system clock
- reset, in, 1, synchronous, active-high
- i_lock_en, in, 1, enables genlock to the upstream frame pulse
- i_frame_sync, in, 1, single-clk frame-end pulse from the PAL upsampler
- o_hd_clk, out, 1, square pixel clock for the upsampler and encoder
- o_pix_en, out, 1, one-clk pixel strobe
- o_hsync, out, 1, active-high horizontal sync
- o_vsync, out, 1, active-high vertical sync
- o_de, out, 1, data enable
- o_hcount, out, 12, current pixel index
- o_vcount, out, 11, current line index
- o_frame_start, out, 1, one-clk pulse at hcount=0, vcount=0
- o_lock_jump, out, 1, one-clk pulse when genlock altered vcount
REQ-003 SHALL use clock clk and reset reset (synchronous, active-high).

Function
REQ-004 SHALL use H_TOTAL=H_ACT+H_FP+H_SYNC+H_BP (1980) and V_TOTAL=V_ACT+V_FP+V_SYNC+V_BP (750).
REQ-005 SHALL assert o_pix_en for one clk every CLK_DIV clks, using a free-running divider counter 0..CLK_DIV-1.
REQ-006 SHALL drive o_hd_clk high while the divider is < CLK_DIV/2, otherwise low; the falling edge is at mid-pixel.
REQ-007 SHALL, on pix_en, increment hcount and wrap it from H_TOTAL-1 to 0; vcount SHALL advance only on that wrap and wrap from V_TOTAL-1 to 0.
REQ-008 SHALL assert o_hsync iff H_ACT+H_FP <= hcount < H_ACT+H_FP+H_SYNC.
REQ-009 SHALL assert o_vsync iff V_ACT+V_FP <= vcount < V_ACT+V_FP+V_SYNC; o_vsync changes only at a line wrap.
REQ-010 SHALL assert o_de iff hcount<H_ACT and vcount<V_ACT.
REQ-011 SHALL register all outputs; sync, de, counts and frame_start SHALL change on the clk edge that registers pix_en and SHALL always reflect the same pixel (zero skew).
REQ-012 SHALL, when i_frame_sync=1 and i_lock_en=1, set a pending flag; at the next line wrap vcount SHALL load LOCK_LINE instead of incrementing, and the flag SHALL clear.
REQ-013 SHALL apply a frame_sync pulse that arrives in the same clk as a line wrap at that wrap.
REQ-014 SHALL ignore further frame_sync pulses while the flag is pending; there is no queueing.
REQ-015 SHALL clear the pending flag and ignore pulses while i_lock_en=0.
REQ-016 SHALL pulse o_lock_jump one clk with the wrap only if the loaded LOCK_LINE differs from the naturally incremented value.
REQ-017 SHALL keep hcount, o_hd_clk and the divider phase unaffected by genlock; only vcount is modified.

Reset
REQ-018 On reset, the divider, hcount, vcount and pending flag SHALL be 0.
REQ-019 On reset, o_hd_clk=1 and o_pix_en, o_hsync, o_vsync, o_de, o_frame_start, o_lock_jump=0.
REQ-020 Reset mid-frame SHALL restart timing; the first pix_en after release SHALL occur CLK_DIV clks later with hcount=0, vcount=0 and o_frame_start=1.

Structure
REQ-021 The 720p50 timing constants and the H_TOTAL/V_TOTAL derivations SHALL live in shared package hd_timing_pkg, which the upsampler's vertical translator also uses.
REQ-022 The divider, pix_en and o_hd_clk SHALL be one sub-module, hd_pix_clk_div; the counters and genlock stay in the top module.

Verification
REQ-023 Free run with defaults: period of o_pix_en=2 clks; hsync high 40 pixels starting at hcount=1720; 1980 pixels per line.
REQ-024 Full frame: vsync high for vcount 725..729; de count=1280*720=921600 per frame; one frame_start per 750 lines.
REQ-025 Genlock: i_lock_en=1, pulse at vcount=100 with LOCK_LINE=0 -> next line vcount=0 and o_lock_jump=1; a pulse at vcount=749 -> no o_lock_jump.
REQ-026 Simultaneous events: pulse in the same clk as the hcount wrap -> that wrap loads LOCK_LINE; a second pulse while pending -> no extra jump.
REQ-027 Disabled lock and reset: i_lock_en=0 with a pulse -> vcount increments normally; reset at vcount=400 -> all outputs at reset values, then frame_start 2 clks after release.
